cpu55_seq_ctrl: RTL and testbench
=================================

Name: cpu55_seq_ctrl

Overview:
- Multi-cycle sequencer for the cpu55 datapath. It sits between the combinational `controlunit` decoder and the PC, IR, register file and memory ports.
- Steps each instruction through fetch, decode, execute, memory and writeback phases.
- Qualifies the decoder's write strobes (`wrf`, `wena`) and PC select (`pcsource`) so they act only in the correct phase.
- Stalls on the memory ready handshakes and flags a hung memory access.

Parameters:
- TIMEOUT, 16, max consecutive cycles waiting on `imem_ready` or `dmem_ready` before entering ERR; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode field of the current IR.
- wrf_dec  in  1  register-file write enable from `controlunit`.
- wena_dec  in  1  data-memory write enable from `controlunit`.
- pcsource_dec  in  2  PC select from `controlunit`.
- imem_ready  in  1  instruction memory has valid data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load IR.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- rf_we  out  1  qualified register-file write.
- pc_we  out  1  update PC.
- pcsource  out  2  qualified PC select to the PC mux.
- state  out  3  current state, for debug.
- err  out  1  sticky memory-timeout error.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5. Codes 6–7 are illegal and go to IF on the next edge.
- Reset: while rst=1 at an edge, the next values are state=IF, err=0, retired=0, wait counter=0.
  - While rst is high, all strobes (`imem_req`, `ir_we`, `dmem_req`, `dmem_we`, `rf_we`, `pc_we`) are forced to 0 and `pcsource`=00.
  - Reset mid-operation (any state, including a MEM stall) abandons the instruction. No partial write is issued after rst is seen.
- Outputs are combinational from the state register and current inputs. Strobe pulses are single-cycle.
- Instruction classes:
  - load: op[5:3]=100.
  - store: op[5:3]=101.
  - all other opcodes are ALU/branch/jump.
- IF:
  - imem_req=1.
  - If imem_ready=1: ir_we=1, next state ID.
  - Otherwise stay in IF.
- ID: all strobes 0; next state EX. Decoder outputs are stable from here on.
- EX:
  - Load or store: next state MEM; no strobes.
  - Any other opcode: pc_we=1, pcsource=pcsource_dec, rf_we=wrf_dec, retired+1, next state IF. This covers jal-style cases where both writes occur.
- MEM:
  - dmem_req=1.
  - dmem_we=wena_dec, asserted only for store opcodes; forced 0 for loads regardless of wena_dec.
  - On dmem_ready=1:
    - load: next state WB.
    - store: pc_we=1, pcsource=00, retired+1, next state IF.
  - Otherwise stay in MEM.
- WB: rf_we=1, pc_we=1, pcsource=00, retired+1, next state IF.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in IF with imem_ready=0, or in MEM with dmem_ready=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with ready still low: next state ERR, err set to 1.
  - Ready arriving on the same cycle the limit would be hit takes priority: the access completes normally.
- ERR:
  - All strobes 0, err=1.
  - Held until rst; only rst exits ERR.
- `retired` wraps modulo 2^CNT_W with no flag.
- Latency with ready signals tied high:
  - ALU/branch/jump: 3 cycles (IF, ID, EX).
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each stall cycle adds 1.

Test Plan:
- ALU op: op=000000, wrf_dec=1, pcsource_dec=00, ready signals high → states IF,ID,EX; in EX rf_we=1, pc_we=1, pcsource=00; retired=1 after 3 cycles.
- Branch taken: op=000100, pcsource_dec=01, wrf_dec=0 → in EX pcsource=01, pc_we=1, rf_we=0; next state IF.
- Load with dmem_ready low for 2 MEM cycles: op=100011 → dmem_req high 3 cycles, dmem_we=0, then WB with rf_we=1, pc_we=1; total 7 cycles; retired +1.
- Store: op=101011, wena_dec=1, dmem_ready high → in MEM dmem_we=1, pc_we=1, rf_we=0; 4 cycles total.
- Timeout: TIMEOUT=4, imem_ready held 0 → after 4 IF cycles state=ERR, err=1, all strobes 0. Raising imem_ready has no effect; rst returns state=IF, err=0.
- Reset mid-MEM: load stalled in MEM, assert rst for 1 cycle → no rf_we or pc_we pulse; state=IF, retired=0 on the following cycle.

Source files
------------

// File: rtl/cpu55_seq_ctrl.sv
// rtl/cpu55_seq_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB sequencer for the cpu55 datapath
// Qualifies decoder strobes by phase, stalls on memory ready, traps hung accesses in ERR.
module cpu55_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             wrf_dec,
  input  logic             wena_dec,
  input  logic [1:0]       pcsource_dec,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  localparam logic [31:0] LIMIT = 32'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [31:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q;
  logic             ret_inc;
  logic             stall;
  logic             is_load, is_store, timeout_hit;
  logic             unused_op;

  assign is_load     = (op[5:3] == 3'b100);
  assign is_store    = (op[5:3] == 3'b101);
  assign unused_op   = ^op[2:0];
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == LIMIT);

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ret_inc  = 1'b0;
    stall    = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pcsource = 2'b00;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end else if (timeout_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          pc_we    = 1'b1;
          pcsource = pcsource_dec;
          rf_we    = wrf_dec;
          ret_inc  = 1'b1;
          state_d  = S_IF;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = wena_dec && is_store;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            ret_inc = 1'b1;
            state_d = S_IF;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        ret_inc = 1'b1;
        state_d = S_IF;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IF;
    endcase

    // Reset abandons the instruction: nothing may be written while it is held.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pcsource = 2'b00;
    end

    if (state_d != state_q) begin
      wait_d = 32'd0;
    end else if (stall) begin
      wait_d = wait_q + 32'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      err_q     <= 1'b0;
      retired_q <= '0;
      wait_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, ret_inc};
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_cpu55_seq_ctrl.sv
// tb/tb_cpu55_seq_ctrl.sv - directed self-checking bench for cpu55_seq_ctrl
// Output vector: {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pcsource}.
module tb_cpu55_seq_ctrl;

  logic       clk, rst;
  logic [5:0] op;
  logic       wrf_dec, wena_dec;
  logic [1:0] pcsource_dec;
  logic       imem_ready, dmem_ready;
  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0] pcsource;
  logic [2:0] state;
  logic       err;
  logic [7:0] retired;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_ret = 8'd0;

  cpu55_seq_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .wrf_dec(wrf_dec), .wena_dec(wena_dec),
    .pcsource_dec(pcsource_dec), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pcsource(pcsource), .state(state), .err(err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pcsource};
  endfunction

  function automatic logic [10:0] ev(input logic [2:0] st, input logic [5:0] strb, input logic [1:0] ps);
    return {st, strb, ps};
  endfunction

  task automatic test_reset;
    rst = 1'b1; op = 6'd0; wrf_dec = 1'b1; wena_dec = 1'b1; pcsource_dec = 2'b11;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    tests++;
    if (outs() !== ev(3'd0, 6'b000000, 2'b00)) begin
      fails++; $display("FAIL reset_outputs got %h exp %h", outs(), ev(3'd0, 6'b000000, 2'b00));
    end
    tests++;
    if (err !== 1'b0 || retired !== 8'd0) begin
      fails++; $display("FAIL reset_err_retired got err=%b ret=%0d exp err=0 ret=0", err, retired);
    end
    exp_ret = 8'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu;
    logic [10:0] exp [3];
    exp = '{ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000011, 2'b00)};
    op = 6'b000000; wrf_dec = 1'b1; wena_dec = 1'b0; pcsource_dec = 2'b00;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs() !== exp[i]) begin
        fails++; $display("FAIL alu_cyc%0d got %h exp %h", i, outs(), exp[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 8'd1;
    #1;
    tests++;
    if (retired !== exp_ret || state !== 3'd0) begin
      fails++; $display("FAIL alu_retired got ret=%0d st=%0d exp ret=%0d st=0", retired, state, exp_ret);
    end
  endtask

  task automatic test_branch;
    logic [10:0] exp [3];
    exp = '{ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000001, 2'b01)};
    op = 6'b000100; wrf_dec = 1'b0; wena_dec = 1'b0; pcsource_dec = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (outs() !== exp[i]) begin
        fails++; $display("FAIL branch_cyc%0d got %h exp %h", i, outs(), exp[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 8'd1;
    #1;
    tests++;
    if (retired !== exp_ret || state !== 3'd0) begin
      fails++; $display("FAIL branch_retired got ret=%0d st=%0d exp ret=%0d st=0", retired, state, exp_ret);
    end
  endtask

  task automatic test_load_stall;
    logic [10:0] exp [7];
    logic        dm  [7];
    exp = '{ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000000, 2'b00),
            ev(3'd3, 6'b001000, 2'b00), ev(3'd3, 6'b001000, 2'b00), ev(3'd3, 6'b001000, 2'b00),
            ev(3'd4, 6'b000011, 2'b00)};
    dm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'b100011; wrf_dec = 1'b1; wena_dec = 1'b1; pcsource_dec = 2'b10; imem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dmem_ready = dm[i];
      #1;
      tests++;
      if (outs() !== exp[i]) begin
        fails++; $display("FAIL load_cyc%0d got %h exp %h", i, outs(), exp[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 8'd1;
    #1;
    tests++;
    if (retired !== exp_ret || state !== 3'd0) begin
      fails++; $display("FAIL load_retired got ret=%0d st=%0d exp ret=%0d st=0", retired, state, exp_ret);
    end
  endtask

  task automatic test_store;
    logic [10:0] exp [4];
    exp = '{ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000000, 2'b00),
            ev(3'd3, 6'b001101, 2'b00)};
    op = 6'b101011; wrf_dec = 1'b1; wena_dec = 1'b1; pcsource_dec = 2'b11;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (outs() !== exp[i]) begin
        fails++; $display("FAIL store_cyc%0d got %h exp %h", i, outs(), exp[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 8'd1;
    #1;
    tests++;
    if (retired !== exp_ret || state !== 3'd0) begin
      fails++; $display("FAIL store_retired got ret=%0d st=%0d exp ret=%0d st=0", retired, state, exp_ret);
    end
  endtask

  // Ready arrives exactly at the timeout limit in both IF and MEM; then a jal-style op follows.
  task automatic test_back_to_back;
    logic [10:0] exp [13];
    logic        im  [13];
    logic        dm  [13];
    exp = '{ev(3'd0, 6'b100000, 2'b00), ev(3'd0, 6'b100000, 2'b00), ev(3'd0, 6'b100000, 2'b00),
            ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000000, 2'b00),
            ev(3'd3, 6'b001100, 2'b00), ev(3'd3, 6'b001100, 2'b00), ev(3'd3, 6'b001100, 2'b00),
            ev(3'd3, 6'b001101, 2'b00),
            ev(3'd0, 6'b110000, 2'b00), ev(3'd1, 6'b000000, 2'b00), ev(3'd2, 6'b000011, 2'b10)};
    im  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wrf_dec = 1'b1; wena_dec = 1'b1; pcsource_dec = 2'b10;
    for (int i = 0; i < 13; i++) begin
      op = (i < 10) ? 6'b101000 : 6'b000011;
      imem_ready = im[i];
      dmem_ready = dm[i];
      #1;
      tests++;
      if (outs() !== exp[i]) begin
        fails++; $display("FAIL b2b_cyc%0d got %h exp %h", i, outs(), exp[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 8'd2;
    #1;
    tests++;
    if (retired !== exp_ret || err !== 1'b0) begin
      fails++; $display("FAIL b2b_retired got ret=%0d err=%b exp ret=%0d err=0", retired, err, exp_ret);
    end
  endtask

  task automatic test_reset_mid_mem;
    op = 6'b100011; wrf_dec = 1'b1; wena_dec = 1'b0; pcsource_dec = 2'b00;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (outs() !== ev(3'd3, 6'b001000, 2'b00)) begin
      fails++; $display("FAIL midmem_stalled got %h exp %h", outs(), ev(3'd3, 6'b001000, 2'b00));
    end
    rst = 1'b1; dmem_ready = 1'b1;
    #1;
    tests++;
    if (outs() !== ev(3'd3, 6'b000000, 2'b00)) begin
      fails++; $display("FAIL midmem_rst_held got %h exp %h", outs(), ev(3'd3, 6'b000000, 2'b00));
    end
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_ret = 8'd0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (outs() !== ev(3'd0, 6'b100000, 2'b00) || retired !== exp_ret) begin
        fails++; $display("FAIL midmem_after_cyc%0d got %h ret=%0d exp %h ret=0", i, outs(), retired,
                          ev(3'd0, 6'b100000, 2'b00));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op = 6'b100011; wena_dec = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (outs() !== ev(3'd0, 6'b100000, 2'b00) || err !== 1'b0) begin
        fails++; $display("FAIL timeout_if_cyc%0d got %h err=%b exp %h err=0", i, outs(), err,
                          ev(3'd0, 6'b100000, 2'b00));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        imem_ready = 1'b1; dmem_ready = 1'b1;
      end
      #1;
      tests++;
      if (outs() !== ev(3'd5, 6'b000000, 2'b00) || err !== 1'b1) begin
        fails++; $display("FAIL timeout_err_cyc%0d got %h err=%b exp %h err=1", i, outs(), err,
                          ev(3'd5, 6'b000000, 2'b00));
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (outs() !== ev(3'd0, 6'b110000, 2'b00) || err !== 1'b0) begin
      fails++; $display("FAIL timeout_recover got %h err=%b exp %h err=0", outs(), err,
                        ev(3'd0, 6'b110000, 2'b00));
    end
    repeat (3) @(negedge clk);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (outs() !== ev(3'd3, 6'b001000, 2'b00)) begin
        fails++; $display("FAIL dmem_stall_cyc%0d got %h exp %h", i, outs(), ev(3'd3, 6'b001000, 2'b00));
      end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    tests++;
    if (outs() !== ev(3'd5, 6'b000000, 2'b00) || err !== 1'b1 || retired !== 8'd0) begin
      fails++; $display("FAIL dmem_timeout got %h err=%b ret=%0d exp %h err=1 ret=0", outs(), err, retired,
                        ev(3'd5, 6'b000000, 2'b00));
    end
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op = 6'b000001; wrf_dec = 1'b0; wena_dec = 1'b0; pcsource_dec = 2'b00;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      repeat (3) @(negedge clk);
      if (i == 254) begin
        #1;
        tests++;
        if (retired !== 8'd255) begin
          fails++; $display("FAIL wrap_255 got %0d exp 255", retired);
        end
      end
    end
    #1;
    tests++;
    if (retired !== 8'd0 || state !== 3'd0) begin
      fails++; $display("FAIL wrap_zero got ret=%0d st=%0d exp ret=0 st=0", retired, state);
    end
  endtask

  initial begin
    rst = 1'b1; op = 6'd0; wrf_dec = 1'b0; wena_dec = 1'b0; pcsource_dec = 2'b00;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_load_stall();
    test_store();
    test_back_to_back();
    test_reset_mid_mem();
    test_timeout();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
